// File: rtl/nibble_serial_adder_pkg.sv
// Shared encodings for the nibble-serial add/subtract unit.
// FSM state encodings, the nibble width, and the signed-overflow rule.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Two's-complement overflow: operands agree in sign but the result does not.
  function automatic logic signed_ovf(input logic a_sign, input logic b_sign,
                                      input logic s_sign);
    return (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_four_bit_adder.sv
// Purely combinational 4-bit ripple adder with carry in and carry out.
module four_bit_adder
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
  assign s     = total[NIBBLE_W-1:0];
  assign cout  = total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract built around a single four_bit_adder, one nibble per
// cycle LSB first, with valid/ready handshakes on both operand and result sides.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t                state;
  logic [WIDTH-1:0]      a_sh;
  logic [WIDTH-1:0]      b_sh;
  logic                  carry;
  logic [IDX_W-1:0]      idx;
  logic                  a_sign;
  logic                  b_sign;
  logic [NIBBLE_W-1:0]   add_s;
  logic                  add_cout;

  four_bit_adder u_adder (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry),
    .s    (add_s),
    .cout (add_cout)
  );

  // NOTE: all state here uses non-blocking assignments so every register sees
  // pre-edge values of the others; blocking would make a_sh shift before the
  // adder result derived from it is captured, depending on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      a_sign    <= 1'b0;
      b_sign    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1; the caller's carry-in is ignored then.
            a_sh     <= in_a;
            b_sh     <= in_sub ? ~in_b : in_b;
            carry    <= in_sub ? 1'b1 : in_cin;
            a_sign   <= in_a[WIDTH-1];
            b_sign   <= in_sub ? ~in_b[WIDTH-1] : in_b[WIDTH-1];
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          out_sum[idx*NIBBLE_W +: NIBBLE_W] <= add_s;
          carry <= add_cout;
          a_sh  <= a_sh >> NIBBLE_W;
          b_sh  <= b_sh >> NIBBLE_W;
          if (idx == LAST_IDX) begin
            out_cout  <= add_cout;
            out_ovf   <= signed_ovf(a_sign, b_sign, add_s[NIBBLE_W-1]);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        ST_DONE: begin
          // Result registers are left untouched so they hold after handoff.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int vectors;
  int miscompares;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand bundle for exactly one edge (the accept edge).
  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after accept until out_valid rises; gives up at 20.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    vectors++;
    if ({out_sum, out_cout, out_ovf} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b want 0/0/0",
               out_sum, out_cout, out_ovf);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Table of arithmetic vectors: a, b, cin, sub, expected sum, cout, ovf.
  task automatic test_arith();
    logic [15:0] ta [7];
    logic [15:0] tb [7];
    logic        tc [7];
    logic        ts [7];
    logic [15:0] es [7];
    logic        ec [7];
    logic        eo [7];
    int cycles;
    ta[0]=16'h1234; tb[0]=16'h4321; tc[0]=0; ts[0]=0; es[0]=16'h5555; ec[0]=0; eo[0]=0;
    ta[1]=16'hFFFF; tb[1]=16'h0001; tc[1]=0; ts[1]=0; es[1]=16'h0000; ec[1]=1; eo[1]=0;
    ta[2]=16'h7FFF; tb[2]=16'h0000; tc[2]=1; ts[2]=0; es[2]=16'h8000; ec[2]=0; eo[2]=1;
    ta[3]=16'h8000; tb[3]=16'h0001; tc[3]=0; ts[3]=1; es[3]=16'h7FFF; ec[3]=1; eo[3]=1;
    ta[4]=16'h0005; tb[4]=16'h0007; tc[4]=0; ts[4]=1; es[4]=16'hFFFE; ec[4]=0; eo[4]=0;
    ta[5]=16'h0005; tb[5]=16'h0007; tc[5]=1; ts[5]=1; es[5]=16'hFFFE; ec[5]=0; eo[5]=0;
    ta[6]=16'h0F0F; tb[6]=16'h00F1; tc[6]=1; ts[6]=0; es[6]=16'h1001; ec[6]=0; eo[6]=0;
    for (int i = 0; i < 7; i++) begin
      start_op(ta[i], tb[i], tc[i], ts[i]);
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++; $display("FAIL arith%0d_busy in_ready got %b want 0", i, in_ready);
      end
      wait_done(cycles);
      vectors++;
      if (cycles !== 4) begin
        miscompares++; $display("FAIL arith%0d_latency got %0d want 4", i, cycles);
      end
      vectors++;
      if ({out_sum, out_cout, out_ovf} !== {es[i], ec[i], eo[i]}) begin
        miscompares++;
        $display("FAIL arith%0d_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, out_sum, out_cout, out_ovf, es[i], ec[i], eo[i]);
      end
      release_result();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL arith%0d_release got valid=%b ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int cycles;
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_done(cycles);
    vectors++;
    if (cycles !== 4) begin
      miscompares++; $display("FAIL bp_latency got %0d want 4", cycles);
    end
    // Offer a competing operand throughout the stall; it must be ignored.
    in_a = 16'hAAAA; in_b = 16'h1111; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {out_sum, out_cout, out_ovf} !== {16'h3333, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold%0d got valid=%b ready=%b sum=%h cout=%b ovf=%b want 1/0/3333/0/0",
                 i, out_valid, in_ready, out_sum, out_cout, out_ovf);
      end
    end
    in_valid = 1'b0;
    release_result();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 16'h3333) begin
      miscompares++;
      $display("FAIL bp_release got valid=%b ready=%b sum=%h want 0/1/3333",
               out_valid, in_ready, out_sum);
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    start_op(16'h0002, 16'h0003, 1'b0, 1'b0);
    wait_done(cycles);
    vectors++;
    if (cycles !== 4 || out_sum !== 16'h0005) begin
      miscompares++;
      $display("FAIL b2b_first got cycles=%0d sum=%h want 4/0005", cycles, out_sum);
    end
    release_result();
    start_op(16'hC000, 16'h4000, 1'b0, 1'b0);
    wait_done(cycles);
    vectors++;
    if (cycles !== 4 || {out_sum, out_cout, out_ovf} !== {16'h0000, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_second got cycles=%0d sum=%h cout=%b ovf=%b want 4/0000/1/0",
               cycles, out_sum, out_cout, out_ovf);
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    int cycles;
    start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        {out_sum, out_cout, out_ovf} !== 18'h0) begin
      miscompares++;
      $display("FAIL midrst_state got ready=%b valid=%b sum=%h cout=%b ovf=%b want 1/0/0000/0/0",
               in_ready, out_valid, out_sum, out_cout, out_ovf);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++; $display("FAIL midrst_stale%0d out_valid got %b want 0", i, out_valid);
      end
    end
    start_op(16'h0100, 16'h0200, 1'b0, 1'b0);
    wait_done(cycles);
    vectors++;
    if (cycles !== 4 || out_sum !== 16'h0300) begin
      miscompares++;
      $display("FAIL midrst_recover got cycles=%0d sum=%h want 4/0300", cycles, out_sum);
    end
    release_result();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    in_cin      = 1'b0;
    in_sub      = 1'b0;
    out_ready   = 1'b0;
    test_reset();
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
